// File: rtl/wb_port_arbiter_if.sv
// Writeback bundle between the execute-stage sources and the register-file write-port arbiter.
interface wb_port_arbiter_if;
  logic [2:0]  src_req;
  logic [14:0] src_addr;
  logic [95:0] src_data;
  logic        flush;
  logic        ovf_clr;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [2:0]  src_full;
  logic [2:0]  src_ovf;
  logic        busy;

  modport master (
    output src_req, src_addr, src_data, flush, ovf_clr,
    input  rf_we, rf_waddr, rf_wdata, src_full, src_ovf, busy
  );

  modport slave (
    input  src_req, src_addr, src_data, flush, ovf_clr,
    output rf_we, rf_waddr, rf_wdata, src_full, src_ovf, busy
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Drains three per-source writeback FIFOs into one registered register-file write port.
// WB_ARB_RR_EN selects round-robin arbitration; default is fixed priority src0 > src1 > src2.
module wb_port_arbiter #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PTR_W = 1
) (
  input logic              clk,
  input logic              reset_n,
  wb_port_arbiter_if.slave wb
);
  localparam int unsigned NSRC  = 3;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [AW-1:0]    addr_mem_q [NSRC][DEPTH];
  logic [AW-1:0]    addr_mem_d [NSRC][DEPTH];
  logic [DW-1:0]    data_mem_q [NSRC][DEPTH];
  logic [DW-1:0]    data_mem_d [NSRC][DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [NSRC];
  logic [PTR_W-1:0] wr_ptr_d [NSRC];
  logic [PTR_W-1:0] rd_ptr_q [NSRC];
  logic [PTR_W-1:0] rd_ptr_d [NSRC];
  logic [CNT_W-1:0] cnt_q [NSRC];
  logic [CNT_W-1:0] cnt_d [NSRC];
  logic [NSRC-1:0]  ovf_q, ovf_d;
  logic [1:0]       last_grant_q, last_grant_d;
  logic             rf_we_q, rf_we_d;
  logic [AW-1:0]    rf_waddr_q, rf_waddr_d;
  logic [DW-1:0]    rf_wdata_q, rf_wdata_d;

  logic [NSRC-1:0]  nonempty;
  logic [NSRC-1:0]  full;
  logic [NSRC-1:0]  push_req;
  logic [NSRC-1:0]  pop;

  // Per-source status; writes to x0 never enter a FIFO.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      nonempty[i] = (cnt_q[i] != '0);
      full[i]     = (cnt_q[i] == CNT_W'(DEPTH));
      push_req[i] = wb.src_req[i] && (wb.src_addr[AW*i +: AW] != '0);
    end
  end

`ifdef WB_ARB_RR_EN
  logic [1:0] cand;

  // Round-robin: search from the source after the last grant.
  always_comb begin
    pop  = '0;
    cand = (last_grant_q == 2'd2) ? 2'd0 : last_grant_q + 2'd1;
    for (int k = 0; k < NSRC; k++) begin
      for (int i = 0; i < NSRC; i++) begin
        if ((pop == '0) && (cand == 2'(i)) && nonempty[i]) pop[i] = 1'b1;
      end
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
    end
  end
`else
  // Fixed priority: lowest index wins.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NSRC; i++) begin
      if ((pop == '0) && nonempty[i]) pop[i] = 1'b1;
    end
  end
`endif

  always_comb begin
    addr_mem_d   = addr_mem_q;
    data_mem_d   = data_mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    ovf_d        = wb.ovf_clr ? '0 : ovf_q;
    last_grant_d = last_grant_q;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    if (wb.flush) begin
      for (int i = 0; i < NSRC; i++) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
        cnt_d[i]    = '0;
      end
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (pop[i]) begin
          rf_we_d      = 1'b1;
          rf_waddr_d   = addr_mem_q[i][rd_ptr_q[i]];
          rf_wdata_d   = data_mem_q[i][rd_ptr_q[i]];
          rd_ptr_d[i]  = rd_ptr_q[i] + PTR_W'(1);
          last_grant_d = 2'(i);
        end
        // A full FIFO still accepts a push when it is popped in the same cycle.
        if (push_req[i] && (!full[i] || pop[i])) begin
          addr_mem_d[i][wr_ptr_q[i]] = wb.src_addr[AW*i +: AW];
          data_mem_d[i][wr_ptr_q[i]] = wb.src_data[DW*i +: DW];
          wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
          cnt_d[i]    = cnt_q[i] + CNT_W'(1) - CNT_W'(pop[i]);
        end else begin
          cnt_d[i] = cnt_q[i] - CNT_W'(pop[i]);
          if (push_req[i]) ovf_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NSRC; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          addr_mem_q[i][j] <= '0;
          data_mem_q[i][j] <= '0;
        end
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      ovf_q        <= '0;
      last_grant_q <= 2'd2;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
    end else begin
      addr_mem_q   <= addr_mem_d;
      data_mem_q   <= data_mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  assign wb.rf_we    = rf_we_q;
  assign wb.rf_waddr = rf_waddr_q;
  assign wb.rf_wdata = rf_wdata_q;
  assign wb.src_full = full;
  assign wb.src_ovf  = ovf_q;
  assign wb.busy     = rf_we_q | (|nonempty);
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: shift-FIFO reference model checked every cycle plus directed literal checks.
module tb_wb_port_arbiter;
  localparam int unsigned DEPTH = 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  wb_port_arbiter_if wb ();

  wb_port_arbiter #(.DEPTH(DEPTH), .PTR_W(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wb      (wb)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int wlog[$];

  // Reference model: each source is an ordered list of {addr,data}, head at index 0.
  logic [36:0] m_fifo [3][DEPTH];
  int          m_cnt  [3];
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [2:0]  m_ovf;
  int          m_lg;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    int g, s;
    logic [2:0] ovf_n;
    logic [4:0] a;
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
      m_we = 1'b0; m_addr = '0; m_data = '0; m_ovf = '0; m_lg = 2;
    end else begin
      g = -1;
      for (int k = 0; k < 3; k++) begin
`ifdef WB_ARB_RR_EN
        s = (m_lg + 1 + k) % 3;
`else
        s = k;
`endif
        if (g < 0 && m_cnt[s] > 0) g = s;
      end
      ovf_n = wb.ovf_clr ? 3'b000 : m_ovf;
      if (wb.flush) begin
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        m_we = 1'b0;
      end else begin
        if (g >= 0) begin
          {m_addr, m_data} = m_fifo[g][0];
          for (int j = 0; j < DEPTH - 1; j++) m_fifo[g][j] = m_fifo[g][j+1];
          m_cnt[g] = m_cnt[g] - 1;
          m_we = 1'b1;
          m_lg = g;
        end else begin
          m_we = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
          a = wb.src_addr[5*i +: 5];
          if (wb.src_req[i] && a != 5'd0) begin
            if (m_cnt[i] < DEPTH) begin
              m_fifo[i][m_cnt[i]] = {a, wb.src_data[32*i +: 32]};
              m_cnt[i] = m_cnt[i] + 1;
            end else begin
              ovf_n[i] = 1'b1;
            end
          end
        end
      end
      m_ovf = ovf_n;
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    logic [2:0] e_full;
    logic       e_busy;
    for (int i = 0; i < 3; i++) e_full[i] = (m_cnt[i] == DEPTH);
    e_busy = m_we | (m_cnt[0] != 0) | (m_cnt[1] != 0) | (m_cnt[2] != 0);
    chk("model_rf_we", 64'(wb.rf_we), 64'(m_we));
    chk("model_rf_waddr", 64'(wb.rf_waddr), 64'(m_addr));
    chk("model_rf_wdata", 64'(wb.rf_wdata), 64'(m_data));
    chk("model_src_full", 64'(wb.src_full), 64'(e_full));
    chk("model_src_ovf", 64'(wb.src_ovf), 64'(m_ovf));
    chk("model_busy", 64'(wb.busy), 64'(e_busy));
    if (wb.rf_we === 1'b1) wlog.push_back(int'(wb.rf_waddr));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb.src_req  = '0;
    wb.src_addr = '0;
    wb.src_data = '0;
    wb.flush    = 1'b0;
    wb.ovf_clr  = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
  endtask

  task automatic burst();
    wb.src_req  = 3'b111;
    wb.src_addr = {5'd5, 5'd4, 5'd3};
    wb.src_data = {32'hC, 32'hB, 32'hA};
    step(1);
    idle();
    step(5);
  endtask

  task automatic chk_order(input string tag);
    chk({tag, "_count"}, 64'(wlog.size()), 64'd3);
    chk({tag, "_first"}, 64'(wlog[0]), 64'd3);
    chk({tag, "_second"}, 64'(wlog[1]), 64'd4);
    chk({tag, "_third"}, 64'(wlog[2]), 64'd5);
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    chk("reset_rf_we", 64'(wb.rf_we), 64'd0);
    chk("reset_busy", 64'(wb.busy), 64'd0);
    chk("reset_ovf", 64'(wb.src_ovf), 64'd0);
    chk("reset_full", 64'(wb.src_full), 64'd0);

    // Single src1 write: two cycles of latency, one pulse.
    wlog.delete();
    wb.src_req  = 3'b010;
    wb.src_addr = {5'd0, 5'd1, 5'd0};
    wb.src_data = {32'h0, 32'h0000_0104, 32'h0};
    step(1);
    idle();
    chk("single_we_early", 64'(wb.rf_we), 64'd0);
    chk("single_busy_pending", 64'(wb.busy), 64'd1);
    step(1);
    chk("single_we", 64'(wb.rf_we), 64'd1);
    chk("single_waddr", 64'(wb.rf_waddr), 64'd1);
    chk("single_wdata", 64'(wb.rf_wdata), 64'h104);
    step(1);
    chk("single_we_drop", 64'(wb.rf_we), 64'd0);
    chk("single_busy_drop", 64'(wb.busy), 64'd0);
    chk("single_count", 64'(wlog.size()), 64'd1);

    // Simultaneous requests from all sources, twice.
    do_reset();
    wlog.delete();
    burst();
    chk_order("burst1");
    wlog.delete();
    burst();
    chk_order("burst2");
    chk("burst_busy", 64'(wb.busy), 64'd0);

    // src1 overflows while src0 keeps competing.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      wb.src_req  = 3'b011;
      wb.src_addr = {5'd0, 5'd7, 5'd6};
      wb.src_data = {32'h0, 32'(32'h100 + c), 32'(32'h200 + c)};
      step(1);
      if (c == 1) chk("ovf_full1_two_pending", 64'(wb.src_full[1]), 64'd1);
    end
    idle();
    chk("ovf_flag", 64'(wb.src_ovf), 64'b010);
    step(8);
    chk("ovf_sticky", 64'(wb.src_ovf), 64'b010);
    chk("ovf_full_drained", 64'(wb.src_full), 64'd0);
    wb.ovf_clr = 1'b1;
    step(1);
    wb.ovf_clr = 1'b0;
    chk("ovf_cleared", 64'(wb.src_ovf), 64'd0);

    // Write to x0 is dropped silently.
    wb.src_req  = 3'b100;
    wb.src_addr = '0;
    wb.src_data = {32'hFFFF_FFFF, 64'h0};
    step(1);
    idle();
    for (int c = 0; c < 3; c++) begin
      chk("x0_we", 64'(wb.rf_we), 64'd0);
      chk("x0_busy", 64'(wb.busy), 64'd0);
      chk("x0_ovf", 64'(wb.src_ovf), 64'd0);
      step(1);
    end

    // Flush discards pending entries and the concurrent request.
    wb.src_req  = 3'b101;
    wb.src_addr = {5'd9, 5'd0, 5'd8};
    wb.src_data = {32'h99, 32'h0, 32'h88};
    step(2);
    wb.flush    = 1'b1;
    wb.src_req  = 3'b010;
    wb.src_addr = {5'd0, 5'd10, 5'd0};
    wb.src_data = {32'h0, 32'h1010, 32'h0};
    step(1);
    idle();
    wlog.delete();
    chk("flush_we", 64'(wb.rf_we), 64'd0);
    chk("flush_busy", 64'(wb.busy), 64'd0);
    step(5);
    chk("flush_no_writes", 64'(wlog.size()), 64'd0);

    // Asynchronous reset mid-cycle with entries pending.
    wb.src_req  = 3'b111;
    wb.src_addr = {5'd13, 5'd12, 5'd11};
    wb.src_data = {32'h3, 32'h2, 32'h1};
    step(1);
    idle();
    step(1);
    #2 reset_n = 1'b0;
    #1;
    chk("areset_we", 64'(wb.rf_we), 64'd0);
    chk("areset_busy", 64'(wb.busy), 64'd0);
    chk("areset_waddr", 64'(wb.rf_waddr), 64'd0);
    chk("areset_wdata", 64'(wb.rf_wdata), 64'd0);
    step(2);
    wlog.delete();
    reset_n = 1'b1;
    step(5);
    chk("areset_no_writes", 64'(wlog.size()), 64'd0);
    chk("areset_busy_after", 64'(wb.busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
